// File: rtl/alu_display_ctrl_if.sv
// Bus between the ALU display controller, the ALU datapath and the user/display side.
// The controller connects through the slave modport; the driving side uses master.
interface alu_display_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             c_out;
  logic             DispCont;
  logic [3:0]       OpCode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] out;
  logic [2:0]       op;
  logic             mode;
  logic             c_in;
  logic [4:0]       digit_holder;
  logic [7:0]       an;
  logic             conv_busy;

  modport master (
    output c_out, DispCont, OpCode, A, B, out,
    input  op, mode, c_in, digit_holder, an, conv_busy
  );

  modport slave (
    input  c_out, DispCont, OpCode, A, B, out,
    output op, mode, c_in, digit_holder, an, conv_busy
  );
endinterface

// File: rtl/alu_display_ctrl.sv
// ALU front-end controller: OpCode decode, iterative binary-to-BCD conversion of the
// ALU result, and an 8-digit multiplexed display scanner.
module alu_display_ctrl #(
  parameter int WIDTH       = 4,
  parameter int BCD_DIGITS  = 2,
  parameter int REFRESH_DIV = 100000
) (
  input logic               CLK100MHZ,
  input logic               reset,
  alu_display_ctrl_if.slave bus
);
  localparam int H     = WIDTH / 4;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

  conv_state_e      state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             mode_q, mode_d, c_in_q, c_in_d;
  logic [WIDTH-1:0] conv_val_q, conv_val_d, shreg_q, shreg_d, last_val_q, last_val_d;
  logic [BCD_W-1:0] scratch_q, scratch_d, disp_bcd_q, disp_bcd_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       an_q, an_d;
  logic [4:0]       dh_q, dh_d;
  logic [4:0]       code;
  logic             tick;
  logic             minus;
  int               pos;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    add3 = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) add3[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
  endfunction

  always_comb begin
    {mode_d, op_d, c_in_d} = 5'b0_000_0;
    case (bus.OpCode)
      4'b0000: {mode_d, op_d, c_in_d} = 5'b1_000_0;
      4'b0001: {mode_d, op_d, c_in_d} = 5'b1_001_0;
      4'b0010: {mode_d, op_d, c_in_d} = 5'b0_110_0;
      4'b0011: {mode_d, op_d, c_in_d} = 5'b0_111_0;
      4'b0100: {mode_d, op_d, c_in_d} = 5'b1_010_0;
      4'b0101: {mode_d, op_d, c_in_d} = 5'b1_011_1;
      4'b0110: {mode_d, op_d, c_in_d} = 5'b1_110_0;
      4'b0111: {mode_d, op_d, c_in_d} = 5'b1_111_1;
      4'b1000: {mode_d, op_d, c_in_d} = 5'b1_100_0;
      4'b1001: {mode_d, op_d, c_in_d} = 5'b1_101_1;
      4'b1010: {mode_d, op_d, c_in_d} = 5'b0_000_0;
      4'b1011: {mode_d, op_d, c_in_d} = 5'b0_001_0;
      4'b1100: {mode_d, op_d, c_in_d} = 5'b0_010_0;
      4'b1101: {mode_d, op_d, c_in_d} = 5'b0_011_0;
      4'b1110: {mode_d, op_d, c_in_d} = 5'b0_100_0;
      default: {mode_d, op_d, c_in_d} = 5'b0_101_0;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.out != last_val_q) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The displayed digits only change in DONE, so a new result arriving mid-conversion
  // is picked up by the mismatch test once the FSM is back in IDLE.
  always_comb begin
    conv_val_d = conv_val_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    bit_cnt_d  = bit_cnt_q;
    disp_bcd_d = disp_bcd_q;
    last_val_d = last_val_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: busy_d = (state_d == LOAD);
      LOAD: begin
        conv_val_d = bus.out;
        shreg_d    = bus.out;
        scratch_d  = '0;
        bit_cnt_d  = '0;
      end
      SHIFT: begin
        {scratch_d, shreg_d} = {add3(scratch_q), shreg_q} << 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      DONE: begin
        disp_bcd_d = scratch_q;
        last_val_d = conv_val_q;
        busy_d     = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign minus = mode_q & ~bus.c_out & ~(bus.OpCode inside {4'b0100, 4'b0110, 4'b1000});

  always_comb begin
    tick  = (pre_q == PRE_W'(REFRESH_DIV - 1));
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    idx_d = tick ? idx_q + 3'd1 : idx_q;
    pos   = int'(idx_d);
    code  = 5'd16;
    if (bus.DispCont) begin
      if (pos < H)          code = {1'b0, bus.B[4*pos +: 4]};
      else if (pos < 2 * H) code = {1'b0, bus.A[4*(pos-H) +: 4]};
      else if (pos == 2 * H) code = {1'b0, bus.OpCode};
    end else begin
      if (pos < BCD_DIGITS)                code = {1'b0, disp_bcd_q[4*pos +: 4]};
      else if (pos == BCD_DIGITS && minus) code = 5'd17;
    end
    an_d = tick ? ~(8'd1 << idx_d) : an_q;
    dh_d = tick ? code : dh_q;
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      op_q       <= 3'b000;
      mode_q     <= 1'b0;
      c_in_q     <= 1'b0;
      conv_val_q <= '0;
      shreg_q    <= '0;
      last_val_q <= '0;
      scratch_q  <= '0;
      disp_bcd_q <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
      pre_q      <= '0;
      idx_q      <= 3'd7;
      an_q       <= 8'hFF;
      dh_q       <= 5'd16;
    end else begin
      op_q       <= op_d;
      mode_q     <= mode_d;
      c_in_q     <= c_in_d;
      conv_val_q <= conv_val_d;
      shreg_q    <= shreg_d;
      last_val_q <= last_val_d;
      scratch_q  <= scratch_d;
      disp_bcd_q <= disp_bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      dh_q       <= dh_d;
    end
  end

  assign bus.op           = op_q;
  assign bus.mode         = mode_q;
  assign bus.c_in         = c_in_q;
  assign bus.an           = an_q;
  assign bus.digit_holder = dh_q;
  assign bus.conv_busy    = busy_q;
endmodule

// File: tb/tb_alu_display_ctrl.sv
// Directed bench for alu_display_ctrl: a 4-bit instance with a slow scan and an
// 8-bit, 3-digit instance scanning every cycle.
module tb_alu_display_ctrl;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt;
  logic idle_seen;
  logic [4:0] cap4 [8];
  logic [4:0] cap8 [8];
  logic [4:0] dec_exp [16];

  alu_display_ctrl_if #(.WIDTH(4)) bus4 ();
  alu_display_ctrl_if #(.WIDTH(8)) bus8 ();

  alu_display_ctrl #(.WIDTH(4), .BCD_DIGITS(2), .REFRESH_DIV(4)) dut4 (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus4)
  );

  alu_display_ctrl #(.WIDTH(8), .BCD_DIGITS(3), .REFRESH_DIV(1)) dut8 (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus8)
  );

  always #5 clk = ~clk;

  // Remember the last code shown at each digit position.
  always @(negedge clk) begin
    for (int p = 0; p < 8; p++) begin
      if (bus4.an == ~(8'd1 << p)) cap4[p] = bus4.digit_holder;
      if (bus8.an == ~(8'd1 << p)) cap8[p] = bus8.digit_holder;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] opc, input logic [3:0] a, input logic [3:0] b,
                               input logic disp, input logic cout);
    bus4.OpCode   = opc;
    bus4.A        = a;
    bus4.B        = b;
    bus4.DispCont = disp;
    bus4.c_out    = cout;
  endtask

  task automatic scan_wait(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    dec_exp = '{5'b10000, 5'b10010, 5'b01100, 5'b01110, 5'b10100, 5'b10111, 5'b11100, 5'b11111,
                5'b11000, 5'b11011, 5'b00000, 5'b00010, 5'b00100, 5'b00110, 5'b01000, 5'b01010};
    applyStimulus(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    bus4.out      = '0;
    bus8.OpCode   = 4'h0;
    bus8.A        = '0;
    bus8.B        = '0;
    bus8.DispCont = 1'b0;
    bus8.c_out    = 1'b0;
    bus8.out      = '0;

    // reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_op",   32'(bus4.op), 0);
    checkOutput("rst_mode", 32'(bus4.mode), 0);
    checkOutput("rst_cin",  32'(bus4.c_in), 0);
    checkOutput("rst_an",   32'(bus4.an), 32'hFF);
    checkOutput("rst_dh",   32'(bus4.digit_holder), 16);
    checkOutput("rst_busy", 32'(bus4.conv_busy), 0);
    checkOutput("rst_an8",  32'(bus8.an), 32'hFF);

    // first terminal count selects position 0, then the scan walks every 4 cycles
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_tick_an", 32'(bus4.an), 32'hFF);
    @(negedge clk);
    checkOutput("first_tick_an", 32'(bus4.an), 32'hFE);
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] exp_an;
      exp_an = ~(8'd1 << (k % 8));
      repeat (4) @(negedge clk);
      checkOutput($sformatf("scan_an_%0d", k), 32'(bus4.an), 32'(exp_an));
    end

    // decode sweep, one-cycle latency
    for (int i = 0; i < 16; i++) begin
      bus4.OpCode = 4'(i);
      @(negedge clk);
      checkOutput($sformatf("decode_%0d", i), 32'({bus4.mode, bus4.op, bus4.c_in}), 32'(dec_exp[i]));
    end
    bus4.OpCode = 4'b0101;
    @(negedge clk);
    checkOutput("dec5_mode", 32'(bus4.mode), 1);
    checkOutput("dec5_op",   32'(bus4.op), 3);
    checkOutput("dec5_cin",  32'(bus4.c_in), 1);

    // 4-bit conversion of 15
    bus4.out = 4'hF;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus4.conv_busy) busy_cnt++;
      else if (busy_cnt != 0) break;
    end
    checkOutput("busy_len_w4", 32'(busy_cnt), 6);
    scan_wait(40);
    checkOutput("w4_pos0", 32'(cap4[0]), 5);
    checkOutput("w4_pos1", 32'(cap4[1]), 1);
    checkOutput("minus_op5", 32'(cap4[2]), 17);
    checkOutput("w4_pos3", 32'(cap4[3]), 16);

    applyStimulus(4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
    scan_wait(40);
    checkOutput("minus_op4", 32'(cap4[2]), 16);
    applyStimulus(4'b0101, 4'h0, 4'h0, 1'b0, 1'b1);
    scan_wait(40);
    checkOutput("minus_cout1", 32'(cap4[2]), 16);

    // operand display
    applyStimulus(4'b0101, 4'h3, 4'hC, 1'b1, 1'b0);
    scan_wait(40);
    checkOutput("opnd_pos0", 32'(cap4[0]), 12);
    checkOutput("opnd_pos1", 32'(cap4[1]), 3);
    checkOutput("opnd_pos2", 32'(cap4[2]), 5);
    checkOutput("opnd_pos3", 32'(cap4[3]), 16);
    checkOutput("opnd_pos7", 32'(cap4[7]), 16);

    // 8-bit conversion of 255, result changes to 9 in the middle of SHIFT
    @(negedge clk);
    bus8.out = 8'd255;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus8.conv_busy) busy_cnt++;
      else if (busy_cnt != 0) break;
      if (k == 4) bus8.out = 8'd9;
    end
    checkOutput("busy_len_w8", 32'(busy_cnt), 10);
    scan_wait(10);
    checkOutput("w8_first_pos0", 32'(cap8[0]), 5);
    checkOutput("w8_first_pos1", 32'(cap8[1]), 5);
    checkOutput("w8_first_pos2", 32'(cap8[2]), 2);
    idle_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus8.conv_busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    checkOutput("w8_second_done", 32'(idle_seen), 1);
    scan_wait(10);
    checkOutput("w8_second_pos0", 32'(cap8[0]), 9);
    checkOutput("w8_second_pos1", 32'(cap8[1]), 0);
    checkOutput("w8_second_pos2", 32'(cap8[2]), 0);

    // reset in the middle of a conversion
    applyStimulus(4'b0101, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus4.out = 4'h7;
    repeat (3) @(negedge clk);
    checkOutput("midconv_busy", 32'(bus4.conv_busy), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_an",   32'(bus4.an), 32'hFF);
    checkOutput("async_dh",   32'(bus4.digit_holder), 16);
    checkOutput("async_busy", 32'(bus4.conv_busy), 0);
    checkOutput("async_mode", 32'(bus4.mode), 0);
    bus4.out = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    scan_wait(40);
    checkOutput("abort_pos0", 32'(cap4[0]), 0);
    checkOutput("abort_pos1", 32'(cap4[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
